// File: rtl/rf_fill_fetch_if.sv
// Memory read port used by the fill-fetch stage: a request held until
// acknowledged, with read data returned in the acknowledge cycle.
interface rf_fill_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/rf_fill_fetch.sv
// Fill-fetch stage sitting just ahead of writeback. It looks across the
// packed per-core register-file image for entries waiting on a memory fill,
// picks one round-robin, reads its tag from memory and then emits a single
// write-back strobe that unlocks every entry carrying that tag. Only one
// fill is ever in flight, and a short cooldown after each write-back lets
// the RF image catch up before the next scan.
module rf_fill_fetch #(
    parameter int NCORES   = 4,
    parameter int COOLDOWN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCORES*35-1:0]  rf_in,
    rf_fill_fetch_if.master       mem,
    output logic                  wb_en_out,
    output logic [15:0]           val_out,
    output logic [15:0]           ptr_out,
    output logic                  busy
);
    localparam int ENTRY_W = 35;
    localparam int PW      = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WB,
        HOLD
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     rr_ptr, rr_ptr_n;
    logic [3:0]        cnt, cnt_n;
    logic              req_q, req_n;
    logic [15:0]       addr_q, addr_n;
    logic              wb_q, wb_n;
    logic [15:0]       val_q, val_n;
    logic [15:0]       ptr_q, ptr_n;

    logic [NCORES-1:0] need;
    logic [15:0]       tag_arr [NCORES];
    logic              unused_val_bits;
    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     cand;

    // Split the packed image into a per-core "needs a fill" flag and tag.
    always_comb begin
        unused_val_bits = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            need[i]         = rf_in[i*ENTRY_W + 34] & rf_in[i*ENTRY_W + 33] & rf_in[i*ENTRY_W + 32];
            tag_arr[i]      = rf_in[i*ENTRY_W + 16 +: 16];
            unused_val_bits = unused_val_bits ^ (^rf_in[i*ENTRY_W +: 16]);
        end
    end

    // Round-robin search: first needing entry at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NCORES; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NCORES);
            if (!grant_found && need[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state and next-register values for the fetch sequence.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        cnt_n    = cnt;
        req_n    = req_q;
        addr_n   = addr_q;
        wb_n     = 1'b0;
        val_n    = val_q;
        ptr_n    = ptr_q;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    addr_n   = tag_arr[grant_idx];
                    req_n    = 1'b1;
                    rr_ptr_n = PW'((int'(grant_idx) + 1) % NCORES);
                    state_n  = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    val_n   = mem.mem_rdata;
                    ptr_n   = addr_q;
                    wb_n    = 1'b1;
                    req_n   = 1'b0;
                    state_n = WB;
                end
            end
            WB: begin
                cnt_n   = 4'(COOLDOWN - 1);
                state_n = HOLD;
            end
            HOLD: begin
                if (cnt <= 4'd1) begin
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            req_q  <= 1'b0;
            addr_q <= '0;
            wb_q   <= 1'b0;
            val_q  <= '0;
            ptr_q  <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            cnt    <= cnt_n;
            req_q  <= req_n;
            addr_q <= addr_n;
            wb_q   <= wb_n;
            val_q  <= val_n;
            ptr_q  <= ptr_n;
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign wb_en_out    = wb_q;
    assign val_out      = val_q;
    assign ptr_out      = ptr_q;
    assign busy         = (state != IDLE);

endmodule
